// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter family.
//   state_t   : transmitter FSM encoding (IDLE = nothing to send, SHIFT = word in shifter)
//   DEF_WIDTH : default serial word width
//   CNT_W     : bit-counter width for the default word width
//   cnt_width : bit-counter width for an arbitrary word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register with full flag.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (clears data and full flag)
//   wr_en   : capture wr_data and set full
//   wr_data : word to store
//   rd_en   : consume the stored word (clears full)
//   rd_data : stored word
//   full    : an unconsumed word is stored
module piso_hold_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // A write in the same cycle as a read wins, so the buffer can be refilled
  // on the cycle it is drained.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd_en) begin
      full_d = 1'b0;
    end
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/piso_16bit.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   ld_valid   : a word is offered on d
//   ld_ready   : a word can be accepted this cycle
//   d          : parallel word, sampled on ld_valid && ld_ready
//   sout       : current serial bit
//   sout_valid : sout holds a valid bit
//   sout_ready : receiver accepts the bit this cycle
//   sout_last  : current bit is the final bit of its word
//   busy       : shifter or holding buffer holds data
module piso_16bit
  import piso_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] d,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int             CW       = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_wr, hold_rd;
  logic             in_shift, load, beat, last_beat;
  logic [WIDTH-1:0] shreg_next;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (hold_wr),
    .wr_data (d),
    .rd_en   (hold_rd),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  // Handshake and output decode
  always_comb begin
    in_shift   = (state_q == SHIFT);
    ld_ready   = rst && !hold_full;
    load       = ld_valid && ld_ready;
    sout_valid = in_shift;
    sout       = in_shift && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    sout_last  = in_shift && (cnt_q == CNT_LAST);
    beat       = sout_valid && sout_ready;
    last_beat  = beat && sout_last;
    busy       = in_shift || hold_full;
    // A load while shifting parks in the buffer, except on the last beat with
    // an empty buffer, where it goes straight to the shifter instead.
    hold_wr    = load && in_shift && !last_beat;
    hold_rd    = last_beat && hold_full;
    shreg_next = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  // Next-state: FSM, shifter, counter
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = d;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (!sout_last) begin
            shreg_d = shreg_next;
            cnt_d   = cnt_q + 1'b1;
          end else if (hold_full) begin
            shreg_d = hold_data;
            cnt_d   = '0;
          end else if (load) begin
            shreg_d = d;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
